// File: rtl/element_cmd_sched_pkg.sv
// ----------------------------------------------------------------------------
// elem_sched_pkg
// Shared types for the element command scheduler:
//   - sched_state_t : scheduler FSM states (IDLE / WAIT / FIRE)
//   - sched_cmd_t   : one queued command (trigger time + element fields)
//   - sat_inc16     : saturating 16-bit increment used by the late counter
// The struct field widths match the default widths of element_cmd_sched.
// ----------------------------------------------------------------------------
package elem_sched_pkg;

    localparam int TCNT_W = 27;
    localparam int ENV_W  = 12;
    localparam int FREQ_W = 9;
    localparam int PINI_W = 17;
    localparam int AMPX_W = 16;
    localparam int LATE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FIRE = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [TCNT_W-1:0] trigt;
        logic [ENV_W-1:0]  envstart;
        logic [ENV_W-1:0]  envlength;
        logic [FREQ_W-1:0] freqaddr;
        logic [PINI_W-1:0] pini;
        logic [AMPX_W-1:0] ampx;
    } sched_cmd_t;

    localparam int CMD_W = $bits(sched_cmd_t);

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [LATE_W-1:0] sat_inc16(input logic [LATE_W-1:0] v);
        logic [LATE_W-1:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/element_cmd_sched_fifo.sv
// ----------------------------------------------------------------------------
// elem_cmd_fifo
// Command FIFO for the element scheduler. DEPTH must be a power of two (>= 2)
// so the read/write pointers wrap naturally.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   i_flush           synchronous discard of all entries (a push in the same
//                     cycle is discarded as well)
//   i_push, i_data    write one entry (ignored while full)
//   i_pop             drop the head entry (ignored while empty)
//   o_head            current head entry
//   o_level           registered occupancy
//   o_empty           occupancy is zero
//   o_ready           registered "not full"; low while in reset
// ----------------------------------------------------------------------------
module elem_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_empty,
    output logic                     o_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_ready;
    logic [AW:0]      w_level_nxt;
    logic             w_do_push;
    logic             w_do_pop;

    // Qualified push/pop and next occupancy; ready is derived from the next
    // occupancy so it is registered yet exact in the following cycle.
    always_comb begin
        w_do_push = i_push & r_ready & ~i_flush;
        w_do_pop  = i_pop & (r_level != LVL_ZERO) & ~i_flush;
        if (i_flush) begin
            w_level_nxt = LVL_ZERO;
        end else if (w_do_push & ~w_do_pop) begin
            w_level_nxt = r_level + LVL_ONE;
        end else if (~w_do_push & w_do_pop) begin
            w_level_nxt = r_level - LVL_ONE;
        end else begin
            w_level_nxt = r_level;
        end
    end

    // Pointers, occupancy and ready flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_level  <= LVL_ZERO;
            r_ready  <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= PTR_ZERO;
                r_rd_ptr <= PTR_ZERO;
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
            end
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt < LVL_FULL);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_empty = (r_level == LVL_ZERO);
    assign o_ready = r_ready;

endmodule

// File: rtl/element_cmd_sched.sv
// ----------------------------------------------------------------------------
// element_cmd_sched
// Queues timed commands for one synthesis element and issues each one as a
// single-cycle strobe when the element timebase reaches its trigger time.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        command push handshake
//   cmd_trigt                    absolute fire time (compared against tcnt)
//   cmd_envstart, cmd_envlength  envelope start / length (length 0 = CW)
//   cmd_freqaddr, cmd_pini,
//   cmd_ampx                     frequency address, initial phase, amplitude
//   tcnt                         free-running element timebase
//   elem_busy                    element busy indication
//   flush                        synchronous discard of all queued commands
//   cmdstb                       one-cycle command strobe to the element
//   envstart .. ampx             registered fields of the last fired command
//   level                        FIFO occupancy
//   collide                      sticky: a command fired while elem_busy high
//   late_cnt                     saturating count of dropped late commands
//
// Build option ELEMENT_CMD_SCHED_LATECHK_EN: when defined, a command whose
// trigger time has already passed is discarded without a strobe and counted
// in late_cnt. When undefined, late commands fire at once and late_cnt is 0.
//
// Struct widths come from elem_sched_pkg; keep TCNTWIDTH, ENV_ADDRWIDTH and
// FREQ_ADDRWIDTH equal to the package widths.
// ----------------------------------------------------------------------------
module element_cmd_sched
    import elem_sched_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TCNTWIDTH      = 27,
    parameter int ENV_ADDRWIDTH  = 12,
    parameter int FREQ_ADDRWIDTH = 9
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [TCNTWIDTH-1:0]      cmd_trigt,
    input  logic [ENV_ADDRWIDTH-1:0]  cmd_envstart,
    input  logic [ENV_ADDRWIDTH-1:0]  cmd_envlength,
    input  logic [FREQ_ADDRWIDTH-1:0] cmd_freqaddr,
    input  logic [16:0]               cmd_pini,
    input  logic [15:0]               cmd_ampx,
    input  logic [TCNTWIDTH-1:0]      tcnt,
    input  logic                      elem_busy,
    input  logic                      flush,
    output logic                      cmdstb,
    output logic [ENV_ADDRWIDTH-1:0]  envstart,
    output logic [ENV_ADDRWIDTH-1:0]  envlength,
    output logic [FREQ_ADDRWIDTH-1:0] freqaddr,
    output logic [16:0]               pini,
    output logic [15:0]               ampx,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      collide,
    output logic [15:0]               late_cnt
);

    sched_cmd_t            w_push_cmd;
    sched_cmd_t            w_head_cmd;
    logic [CMD_W-1:0]      w_head_flat;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [TCNTWIDTH-1:0]  w_delta;
    logic                  w_due;
    logic                  w_late;
    logic                  w_fire_load;
    logic                  w_late_drop;
    sched_state_t          r_state;
    sched_state_t          w_state_nxt;

    logic                      r_cmdstb;
    logic [ENV_ADDRWIDTH-1:0]  r_envstart;
    logic [ENV_ADDRWIDTH-1:0]  r_envlength;
    logic [FREQ_ADDRWIDTH-1:0] r_freqaddr;
    logic [16:0]               r_pini;
    logic [15:0]               r_ampx;
    logic                      r_collide;

    // Pack the incoming command fields.
    always_comb begin
        w_push_cmd.trigt     = cmd_trigt;
        w_push_cmd.envstart  = cmd_envstart;
        w_push_cmd.envlength = cmd_envlength;
        w_push_cmd.freqaddr  = cmd_freqaddr;
        w_push_cmd.pini      = cmd_pini;
        w_push_cmd.ampx      = cmd_ampx;
    end

    assign w_push = cmd_valid & cmd_ready;

    elem_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (flush),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head_flat),
        .o_level (level),
        .o_empty (w_empty),
        .o_ready (cmd_ready)
    );

    assign w_head_cmd = sched_cmd_t'(w_head_flat);

    // Wrap-safe due/late test: the modular distance to the trigger time is
    // zero when due and has its top bit set when the time is already past.
    always_comb begin
        w_delta = w_head_cmd.trigt - tcnt;
        w_due   = (w_delta == {TCNTWIDTH{1'b0}});
        w_late  = w_delta[TCNTWIDTH-1];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; flush always returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (w_due) begin
                        w_state_nxt = ST_FIRE;
                    end else if (w_late) begin
`ifdef ELEMENT_CMD_SCHED_LATECHK_EN
                        w_state_nxt = ST_IDLE;
`else
                        w_state_nxt = ST_FIRE;
`endif
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_FIRE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs: field load on entry to FIRE, pop on leaving FIRE or on a
    // late drop.
    always_comb begin
        w_fire_load = (w_state_nxt == ST_FIRE);
`ifdef ELEMENT_CMD_SCHED_LATECHK_EN
        w_late_drop = (r_state == ST_WAIT) & ~w_due & w_late & ~flush;
`else
        w_late_drop = 1'b0;
`endif
        w_pop = (r_state == ST_FIRE) | w_late_drop;
    end

    // Registered strobe and command fields; the strobe coincides with FIRE
    // and the fields hold until the next fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmdstb    <= 1'b0;
            r_envstart  <= {ENV_ADDRWIDTH{1'b0}};
            r_envlength <= {ENV_ADDRWIDTH{1'b0}};
            r_freqaddr  <= {FREQ_ADDRWIDTH{1'b0}};
            r_pini      <= 17'd0;
            r_ampx      <= 16'd0;
        end else begin
            r_cmdstb <= w_fire_load;
            if (w_fire_load) begin
                r_envstart  <= w_head_cmd.envstart;
                r_envlength <= w_head_cmd.envlength;
                r_freqaddr  <= w_head_cmd.freqaddr;
                r_pini      <= w_head_cmd.pini;
                r_ampx      <= w_head_cmd.ampx;
            end
        end
    end

    // Sticky collision flag: the element was busy during a fire cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_collide <= 1'b0;
        end else if ((r_state == ST_FIRE) && elem_busy) begin
            r_collide <= 1'b1;
        end
    end

`ifdef ELEMENT_CMD_SCHED_LATECHK_EN
    logic [15:0] r_late_cnt;

    // Saturating late-drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_late_cnt <= 16'd0;
        end else if (w_late_drop) begin
            r_late_cnt <= sat_inc16(r_late_cnt);
        end
    end

    assign late_cnt = r_late_cnt;
`else
    assign late_cnt = 16'd0;
`endif

    assign cmdstb    = r_cmdstb;
    assign envstart  = r_envstart;
    assign envlength = r_envlength;
    assign freqaddr  = r_freqaddr;
    assign pini      = r_pini;
    assign ampx      = r_ampx;
    assign collide   = r_collide;

endmodule

// File: doc/element_cmd_sched.md
ELEMENT_CMD_SCHED -- requirements
Module: element_cmd_sched

Interface
- REQ-001 Parameters (name, default, meaning): DEPTH, 4, command FIFO entries (power of 2); TCNTWIDTH, 27, timebase width; ENV_ADDRWIDTH, 12, envelope address width; FREQ_ADDRWIDTH, 9, frequency address width.
- REQ-002 Ports (name, direction, width, meaning):
- REQ-003 clk  in  1  single clock; all logic on rising edge.
- REQ-004 reset_n  in  1  asynchronous, active-low reset.
- REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command push handshake; transfer when both high.
- REQ-006 cmd_trigt  in  TCNTWIDTH  absolute fire time.
- REQ-007 cmd_envstart, cmd_envlength  in  ENV_ADDRWIDTH each  envelope start/length; length 0 means CW.
- REQ-008 cmd_freqaddr  in  FREQ_ADDRWIDTH  frequency table address.
- REQ-009 cmd_pini, cmd_ampx  in  17 / 16  initial phase, amplitude.
- REQ-010 tcnt  in  TCNTWIDTH  free-running element timebase.
- REQ-011 elem_busy  in  1  element busy indication.
- REQ-012 flush  in  1  synchronous discard of all queued commands.
- REQ-013 cmdstb  out  1  one-cycle command strobe to element.
- REQ-014 envstart, envlength, freqaddr, pini, ampx  out  widths as inputs  registered command fields to element.
- REQ-015 level  out  $clog2(DEPTH)+1  FIFO occupancy.
- REQ-016 collide  out  1  sticky: fired while elem_busy high.
- REQ-017 late_cnt  out  16  late-command counter (saturating).

Function
- REQ-018 FIFO SHALL hold DEPTH entries; cmd_ready = (level < DEPTH); push when full SHALL NOT occur.
- REQ-019 FSM states IDLE, WAIT, FIRE; IDLE->WAIT when FIFO non-empty; WAIT->FIRE when head due; FIRE->IDLE after one cycle with head popped.
- REQ-020 Due test: d = (head.trigt - tcnt) mod 2^TCNTWIDTH; due when d == 0; late when d[TCNTWIDTH-1] == 1 (wrap-safe).
- REQ-021 cmdstb SHALL be high exactly in the FIRE cycle, i.e. the cycle after tcnt == trigt is sampled in WAIT (latency 1).
- REQ-022 Output fields SHALL load in the FIRE cycle and hold until the next FIRE.
- REQ-023 If elem_busy is high in FIRE, the command SHALL still fire and collide SHALL set until reset.
- REQ-024 Simultaneous push and pop SHALL leave level unchanged; push in the same cycle as the FIFO goes empty SHALL be accepted.
- REQ-025 flush SHALL empty the FIFO and return FSM to IDLE next cycle; a FIRE cycle coinciding with flush SHALL still strobe.
- REQ-026 Back-to-back commands with consecutive trigt SHALL fire at most once every 2 cycles (IDLE re-entry).

Reset
- REQ-027 reset_n low SHALL force: FSM IDLE, FIFO empty, level 0, cmd_ready 0 during reset and 1 after, cmdstb 0, all fields 0, collide 0, late_cnt 0.
- REQ-028 Reset mid-operation SHALL discard queued commands without a strobe.

Configuration
- REQ-029 Macro ELEMENT_CMD_SCHED_LATECHK_EN defined: a late head in WAIT SHALL be popped without strobe and late_cnt incremented (saturating at 0xFFFF).
- REQ-030 Macro undefined: late commands SHALL fire immediately (next cycle) and late_cnt SHALL be tied to 0.

Structure
- REQ-031 Package elem_sched_pkg SHALL hold the FSM state enum and the command struct typedef (trigt, envstart, envlength, freqaddr, pini, ampx).
- REQ-032 FIFO SHALL be one sub-module, elem_cmd_fifo, parameterized by DEPTH and struct width.

Verification
- REQ-033 Push trigt=100, tcnt from 0 -> single cmdstb in cycle where tcnt==101, fields match command.
- REQ-034 Push 5 commands at DEPTH=4 with far trigt -> cmd_ready low after 4, level=4, 5th accepted after first fire.
- REQ-035 tcnt=2^27-3, trigt=2 -> fires after wrap at tcnt==3, no late count.
- REQ-036 LATECHK_EN, tcnt=500, trigt=400 -> no cmdstb, late_cnt=1; without macro -> cmdstb next cycle.
- REQ-037 elem_busy=1 at fire -> cmdstb asserted, collide=1 until reset_n pulse.
- REQ-038 3 queued, flush then reset_n low mid-WAIT -> level=0, no further cmdstb.
